// File: rtl/ide_fifo_gen.sv
// ide_fifo_gen: parametrised sector FIFO between the IDE register interface
// and the host-side sector transfer logic. It has block-mode sector
// hysteresis, ATAPI packet-in/packet-out readiness, occupancy, sticky
// overflow/underflow flags and a synchronous flush.
module ide_fifo_gen #(
  parameter int DW = 16,
  parameter int AW = 12,
  parameter int SW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clk_en,
  input  logic          flush,
  input  logic [1:0]    mode,
  input  logic [AW:0]   packet_count,
  input  logic [DW-1:0] data_in,
  input  logic          wr,
  input  logic          rd,
  output logic [DW-1:0] data_out,
  output logic          empty,
  output logic          full_hard,
  output logic          sector_avail,
  output logic          packet_in_last,
  output logic          last_in,
  output logic          last_out,
  output logic [AW:0]   level,
  output logic          ovf_err,
  output logic          unf_err
);

  typedef enum logic [1:0] {
    MODE_BLOCK   = 2'b00,
    MODE_PKT_IN  = 2'b01,
    MODE_PKT_OUT = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_e;

  localparam logic [AW:0] FULL_LEVEL = {1'b1, {AW{1'b0}}};

  logic [DW-1:0] mem [2**AW];
  logic [AW:0]   inptr;
  logic [AW:0]   outptr;
  logic          empty_d;
  logic          empty_rd;
  logic          wr_ok;
  logic          rd_ok;
  logic [AW-1:0] rd_addr;
  mode_e         mode_q;

  // Pointer-derived status and the accept qualifiers for this cycle.
  always_comb begin
    mode_q    = mode_e'(mode);
    empty_rd  = (inptr == outptr);
    empty     = empty_rd | empty_d;
    level     = inptr - outptr;
    full_hard = (level == FULL_LEVEL);
    wr_ok     = clk_en & ~flush & wr & ~full_hard;
    rd_ok     = clk_en & ~flush & rd & ~empty;
    // Read ahead: fetch the word that will be the head after this cycle.
    rd_addr   = outptr[AW-1:0] + {{(AW-1){1'b0}}, rd_ok};
    last_in   = (inptr[SW-1:0]  == {SW{1'b1}});
    last_out  = (outptr[SW-1:0] == {SW{1'b1}});
    packet_in_last = (mode_q == MODE_PKT_IN) && (inptr == packet_count) &&
                     empty_rd && (inptr != '0);
    case (mode_q)
      MODE_PKT_IN:  sector_avail = (inptr == packet_count) && !empty_rd;
      MODE_PKT_OUT: sector_avail = (inptr == packet_count);
      default:      sector_avail = (inptr[AW:SW] != outptr[AW:SW]);
    endcase
  end

  // Storage write port.
  // NOTE: the RAM has no reset so it maps onto block RAM; stale contents are
  // never visible because the pointers and empty flag are reset instead.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[inptr[AW-1:0]] <= data_in;
  end

  // Pointers, delayed empty, sticky errors and the registered head word.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values, giving the RAM its read-before-write behaviour.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inptr    <= '0;
      outptr   <= '0;
      empty_d  <= 1'b1;
      ovf_err  <= 1'b0;
      unf_err  <= 1'b0;
      data_out <= '0;
    end else if (clk_en) begin
      if (flush) begin
        inptr    <= '0;
        outptr   <= '0;
        empty_d  <= 1'b0;
        ovf_err  <= 1'b0;
        unf_err  <= 1'b0;
        data_out <= '0;
      end else begin
        empty_d  <= empty_rd;
        data_out <= mem[rd_addr];
        if (wr_ok) inptr  <= inptr + 1'b1;
        if (rd_ok) outptr <= outptr + 1'b1;
        if (wr && full_hard) ovf_err <= 1'b1;
        if (rd && empty)     unf_err <= 1'b1;
      end
    end
  end

endmodule
